// File: rtl/z80_irq_pkg.sv
// Shared types and constants for the Z80 interrupt-control stage.
package z80_irq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ACK_NMI = 2'd1,
    ACK_INT = 2'd2
  } irq_state_t;

  localparam logic [1:0] IM0 = 2'd0;
  localparam logic [1:0] IM1 = 2'd1;
  localparam logic [1:0] IM2 = 2'd2;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/z80_irq_sync.sv
// Pin synchroniser for nmi_n/int_n plus NMI falling-edge detector.
// All flops reset to 1 (pins idle high) so reset never fakes an edge.
module z80_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  input  logic int_n,
  output logic nmi_fall,
  output logic int_sync
);

  logic [STAGES-1:0] nmi_sr;
  logic [STAGES-1:0] int_sr;
  logic              nmi_prev;

  // Shift the pins through the synchroniser chains; remember last synced NMI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_sr   <= '1;
      int_sr   <= '1;
      nmi_prev <= 1'b1;
    end else begin
      nmi_sr   <= {nmi_sr[STAGES-2:0], nmi_n};
      int_sr   <= {int_sr[STAGES-2:0], int_n};
      nmi_prev <= nmi_sr[STAGES-1];
    end
  end

  assign nmi_fall = nmi_prev & ~nmi_sr[STAGES-1];
  assign int_sync = int_sr[STAGES-1];

endmodule

// File: rtl/z80_irq_ctrl.sv
// Z80 interrupt control: IFF1/IFF2, interrupt mode, delayed EI, NMI latch
// and acceptance decision at instruction boundaries.
// Optional macro Z80_IRQ_HALT_EN adds a 'halted' input so acceptance is
// evaluated every cycle while the CPU sits in HALT.
module z80_irq_ctrl
  import z80_irq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int IM_RESET    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insn_done,
  input  logic       insn_ei,
  input  logic       insn_di,
  input  logic       insn_retn,
  input  logic       insn_im,
  input  logic [1:0] im_val,
  input  logic       nmi_n,
  input  logic       int_n,
  input  logic       ack_done,
`ifdef Z80_IRQ_HALT_EN
  input  logic       halted,
`endif
  output logic       take_nmi,
  output logic       take_int,
  output logic       iff1,
  output logic       iff2,
  output logic [1:0] im,
  output logic       ei_pending
);

  irq_state_t state, state_n;
  logic       nmi_latch, nmi_latch_n;
  logic       iff1_n, iff2_n, ei_n;
  logic [1:0] im_n;
  logic       nmi_fall, int_sync;
  logic       upd, eval;

  z80_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .nmi_n    (nmi_n),
    .int_n    (int_n),
    .nmi_fall (nmi_fall),
    .int_sync (int_sync)
  );

  // Instruction updates only in RUN; acceptance also while halted if enabled
  assign upd = (state == RUN) & insn_done;
`ifdef Z80_IRQ_HALT_EN
  assign eval = (state == RUN) & (insn_done | halted);
`else
  assign eval = upd;
`endif

  // Next-state: instruction effects first, then acceptance on top of them
  always_comb begin
    state_n     = state;
    iff1_n      = iff1;
    iff2_n      = iff2;
    ei_n        = ei_pending;
    im_n        = im;
    nmi_latch_n = nmi_latch | nmi_fall;

    if (upd) begin
      if (insn_di) begin
        iff1_n = 1'b0;
        iff2_n = 1'b0;
        ei_n   = 1'b0;
      end else if (insn_ei) begin
        ei_n = 1'b1;
      end else if (ei_pending) begin
        // pending enable takes effect; also wins over RETN
        iff1_n = 1'b1;
        iff2_n = 1'b1;
        ei_n   = 1'b0;
      end else if (insn_retn) begin
        iff1_n = iff2;
      end
      if (insn_im && im_val != 2'b11) im_n = im_val;
    end

    if (eval) begin
      if (nmi_latch) begin
        state_n     = ACK_NMI;
        iff2_n      = iff1_n;
        iff1_n      = 1'b0;
        nmi_latch_n = nmi_fall;
      end else if (!int_sync && iff1 && !ei_pending && !ei_n) begin
        // registered ei_pending blocks the boundary after EI, ei_n blocks EI's own
        state_n = ACK_INT;
        iff1_n  = 1'b0;
        iff2_n  = 1'b0;
      end
    end

    if (state != RUN && ack_done) state_n = RUN;
  end

  // State and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      iff1       <= 1'b0;
      iff2       <= 1'b0;
      ei_pending <= 1'b0;
      im         <= 2'(IM_RESET);
      nmi_latch  <= 1'b0;
    end else begin
      state      <= state_n;
      iff1       <= iff1_n;
      iff2       <= iff2_n;
      ei_pending <= ei_n;
      im         <= im_n;
      nmi_latch  <= nmi_latch_n;
    end
  end

  assign take_nmi = (state == ACK_NMI);
  assign take_int = (state == ACK_INT);

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed self-checking bench for z80_irq_ctrl.
module tb_z80_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       insn_done, insn_ei, insn_di, insn_retn, insn_im;
  logic [1:0] im_val;
  logic       nmi_n, int_n, ack_done;
  logic       take_nmi, take_int, iff1, iff2, ei_pending;
  logic [1:0] im;
`ifdef Z80_IRQ_HALT_EN
  logic       halted = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  z80_irq_ctrl #(.SYNC_STAGES(2), .IM_RESET(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .insn_done  (insn_done),
    .insn_ei    (insn_ei),
    .insn_di    (insn_di),
    .insn_retn  (insn_retn),
    .insn_im    (insn_im),
    .im_val     (im_val),
    .nmi_n      (nmi_n),
    .int_n      (int_n),
    .ack_done   (ack_done),
`ifdef Z80_IRQ_HALT_EN
    .halted     (halted),
`endif
    .take_nmi   (take_nmi),
    .take_int   (take_int),
    .iff1       (iff1),
    .iff2       (iff2),
    .im         (im),
    .ei_pending (ei_pending)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One retiring instruction: kind 0=NOP 1=EI 2=DI 3=RETN 4=IM
  task automatic insn(input int kind, input logic [1:0] v);
    @(negedge clk);
    insn_done = 1'b1;
    insn_ei   = (kind == 1);
    insn_di   = (kind == 2);
    insn_retn = (kind == 3);
    insn_im   = (kind == 4);
    im_val    = v;
    @(negedge clk);
    insn_done = 1'b0; insn_ei = 1'b0; insn_di = 1'b0;
    insn_retn = 1'b0; insn_im = 1'b0; im_val = 2'd0;
  endtask

  task automatic ack();
    @(negedge clk);
    ack_done = 1'b1;
    @(negedge clk);
    ack_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; insn_done = 0; insn_ei = 0; insn_di = 0; insn_retn = 0;
    insn_im = 0; im_val = 0; nmi_n = 1; int_n = 1; ack_done = 0;
    idle(2);
    chk("rst_iff1", {1'b0, iff1}, 2'd0);
    chk("rst_iff2", {1'b0, iff2}, 2'd0);
    chk("rst_ei", {1'b0, ei_pending}, 2'd0);
    chk("rst_im", im, 2'd0);
    chk("rst_take", {take_nmi, take_int}, 2'd0);
    reset = 1'b0;

    // EI, NOP, NOP with INT low
    int_n = 1'b0;
    idle(3);
    insn(1, 0);
    chk("ei_iff1", {1'b0, iff1}, 2'd0);
    chk("ei_pend", {1'b0, ei_pending}, 2'd1);
    chk("ei_take", {1'b0, take_int}, 2'd0);
    insn(0, 0);
    chk("nop1_iff", {iff1, iff2}, 2'b11);
    chk("nop1_pend", {1'b0, ei_pending}, 2'd0);
    chk("nop1_take", {1'b0, take_int}, 2'd0);
    insn(0, 0);
    chk("nop2_take", {take_nmi, take_int}, 2'b01);
    chk("nop2_iff", {iff1, iff2}, 2'b00);
    ack();
    chk("ack_drop", {take_nmi, take_int}, 2'b00);

    // EI, EI, NOP, NOP with INT low
    insn(1, 0);
    chk("eiei1_pend", {1'b0, ei_pending}, 2'd1);
    insn(1, 0);
    chk("eiei2_pend", {1'b0, ei_pending}, 2'd1);
    chk("eiei2_iff1", {1'b0, iff1}, 2'd0);
    insn(0, 0);
    chk("eiei_nop_iff1", {1'b0, iff1}, 2'd1);
    chk("eiei_nop_take", {1'b0, take_int}, 2'd0);
    insn(0, 0);
    chk("eiei_nop2_take", {1'b0, take_int}, 2'd1);
    ack();
    int_n = 1'b1;

    // NMI with iff1=iff2=1
    insn(1, 0);
    insn(0, 0);
    chk("pre_nmi_iff", {iff1, iff2}, 2'b11);
    nmi_n = 1'b0;
    idle(4);
    chk("nmi_wait", {take_nmi, take_int}, 2'b00);
    insn(0, 0);
    chk("nmi_take", {take_nmi, take_int}, 2'b10);
    chk("nmi_iff", {iff1, iff2}, 2'b01);
    insn(0, 0);
    chk("nmi_ignore_done", {take_nmi, 1'b0}, 2'b10);
    ack();
    chk("nmi_drop", {take_nmi, take_int}, 2'b00);
    insn(3, 0);
    chk("retn_iff", {iff1, iff2}, 2'b11);
    nmi_n = 1'b1;
    idle(3);

    // NMI and INT together: NMI wins, INT then masked
    int_n = 1'b0; nmi_n = 1'b0;
    idle(4);
    insn(0, 0);
    chk("both_take", {take_nmi, take_int}, 2'b10);
    ack();
    insn(0, 0);
    chk("both_after", {take_nmi, take_int}, 2'b00);
    nmi_n = 1'b1;

    // EI then DI with INT low; IM handling
    insn(1, 0);
    chk("eidi_ei_take", {1'b0, take_int}, 2'd0);
    insn(2, 0);
    chk("eidi_pend", {1'b0, ei_pending}, 2'd0);
    chk("eidi_iff", {iff1, iff2}, 2'b00);
    insn(0, 0);
    chk("eidi_take", {take_nmi, take_int}, 2'b00);
    insn(4, 2'b11);
    chk("im_illegal", im, 2'd0);
    insn(4, 2'b10);
    chk("im2", im, 2'd2);
    insn(4, 2'b01);
    chk("im1", im, 2'd1);

    // Reset during ACK_INT
    insn(1, 0);
    insn(0, 0);
    insn(0, 0);
    chk("pre_rst_take", {take_nmi, take_int}, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("arst_take", {take_nmi, take_int}, 2'b00);
    chk("arst_iff", {iff1, iff2}, 2'b00);
    chk("arst_pend", {1'b0, ei_pending}, 2'd0);
    chk("arst_im", im, 2'd0);
    int_n = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    insn(0, 0);
    chk("post_rst_take", {take_nmi, take_int}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_irq_ctrl.md
Name: z80_irq_ctrl

Overview:
- Interrupt-control stage feeding the instruction sequencer. Holds IFF1/IFF2 and the interrupt mode, and implements the one-instruction EI delay.
- Latches NMI edges and decides, at each instruction boundary, whether the sequencer must enter an NMI or maskable-interrupt acknowledge sequence.
- Sits between the decoded-instruction retire strobe and the sequencer. The EI/DI instruction formal specs rely on this block for the delayed EI effect.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising nmi_n and int_n (minimum 2).
- IM_RESET, 0, interrupt mode loaded on reset (0..2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- insn_done  in  1  one-cycle strobe: current instruction retired (boundary).
- insn_ei  in  1  retiring instruction is EI (qualified by insn_done).
- insn_di  in  1  retiring instruction is DI.
- insn_retn  in  1  retiring instruction is RETN.
- insn_im  in  1  retiring instruction is IM n.
- im_val  in  2  mode for IM n (00 = 0, 01 = 1, 10 = 2; 11 is illegal and is ignored).
- nmi_n  in  1  asynchronous NMI pin, falling-edge sensitive.
- int_n  in  1  asynchronous INT pin, level, active-low.
- ack_done  in  1  sequencer has finished the acknowledge sequence.
- take_nmi  out  1  sequencer must run the NMI acknowledge.
- take_int  out  1  sequencer must run the INT acknowledge in mode im.
- iff1  out  1  interrupt enable flip-flop 1.
- iff2  out  1  interrupt enable flip-flop 2 (used by LD A,I/R P/V).
- im  out  2  current interrupt mode.
- ei_pending  out  1  EI retired, enable not yet effective.

Behaviour:
- Reset (asynchronous, active-high):
  - iff1 = iff2 = 0, ei_pending = 0, im = IM_RESET.
  - take_nmi = take_int = 0, NMI latch cleared, state = RUN, synchroniser flops = 1.
  - Reset mid-acknowledge abandons the acknowledge with no residue.
- States: RUN, ACK_NMI, ACK_INT.
- Instruction updates apply at insn_done, in RUN only; insn_done is ignored in ACK_*.
  - EI: ei_pending <= 1; iff1/iff2 unchanged this boundary.
  - Any boundary with ei_pending = 1 and a non-EI instruction: iff1 <= 1, iff2 <= 1, ei_pending <= 0.
  - EI followed by EI: ei_pending stays 1; enable is delayed again.
  - DI: iff1 <= 0, iff2 <= 0, ei_pending <= 0. DI wins over a pending EI.
  - RETN: iff1 <= iff2. If ei_pending is also set, the pending-enable rule wins and both become 1.
  - IM n: im <= im_val when im_val != 11.
- NMI path:
  - The synchronised falling edge of nmi_n sets nmi_latch.
  - The latch is held until acceptance; further edges while it is set are absorbed.
- Acceptance, evaluated on the insn_done cycle after that instruction's updates are computed:
  - nmi_latch = 1 -> ACK_NMI; take_nmi = 1 next cycle; iff2 <= iff1 (pre-NMI value); iff1 <= 0; nmi_latch <= 0.
  - Else synchronised int_n = 0, iff1 = 1 (current registered value) and ei_pending = 0 -> ACK_INT; take_int = 1; iff1 <= 0; iff2 <= 0.
  - Consequence: an interrupt is never accepted on the boundary of EI itself or of the instruction after EI.
  - NMI has priority over INT.
- take_nmi/take_int are held high until ack_done, then drop the next cycle and the state returns to RUN.
- ack_done in RUN is ignored.
- An NMI edge during ACK_INT/ACK_NMI is latched and serviced at the next boundary.
- Latency: pin edge to take_* = SYNC_STAGES + edge detect + wait for boundary + 1 cycle.

Optional Feature:
- Macro: Z80_IRQ_HALT_EN.
- When defined:
  - Adds input halted (1 bit: CPU is in HALT).
  - While halted = 1 and state = RUN, acceptance is evaluated every cycle, as if insn_done were high but with no instruction updates.
  - This lets an NMI or enabled INT wake the CPU. ei_pending still blocks INT.
- When undefined:
  - No halted port; acceptance occurs only on insn_done.
  - The sequencer must pulse insn_done for each HALT re-execution.

Decomposition:
- Package z80_irq_pkg holds:
  - state enum (RUN, ACK_NMI, ACK_INT);
  - IM constants (IM0 = 2'd0, IM1 = 2'd1, IM2 = 2'd2);
  - SYNC_STAGES default constant.
- One sub-module: z80_irq_sync. It is a parameterised synchroniser for nmi_n/int_n plus the NMI falling-edge detector, with asynchronous active-high reset to 1.

Test Plan:
- EI, NOP, NOP with int_n = 0 throughout:
  - EI boundary: iff1 = 0, ei_pending = 1.
  - First NOP boundary: iff1 = 1, no take_int.
  - Second NOP boundary: take_int = 1 next cycle, iff1 = iff2 = 0.
- EI, EI, NOP with int_n = 0: no take_int until after the NOP's following boundary; ei_pending stays 1 across both EIs.
- Start iff1 = iff2 = 1; NMI falling edge; boundary:
  - take_nmi = 1, iff1 = 0, iff2 = 1.
  - ack_done, then RETN: iff1 = 1.
- NMI edge and int_n = 0 with iff1 = 1 at the same boundary:
  - take_nmi only.
  - After ack_done, the next boundary gives take_int = 0, because iff1 is now 0.
- EI then DI before the next boundary: ei_pending = 0, iff1 = iff2 = 0, no interrupt accepted. IM with im_val = 11 leaves im = 0.
- Assert reset during ACK_INT with take_int = 1: all outputs 0 and im = IM_RESET immediately (asynchronous); after release, RUN with no spurious take_*.
